// File: rtl/control_unit.sv
// Multi-cycle datapath sequencer: FETCH_A/FETCH_M/DECODE/EXEC[/MEM]/WB; ALU ops take 5 cycles per instruction.
// FETCH_M and MEM stall on mem_ready; outputs are decoded from state plus the held IR fields.
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] op,
    input  logic [2:0] src,
    input  logic [2:0] dst,
    input  logic       z_flag,
    input  logic       mem_ready,
    output logic [2:0] b_flag,
    output logic [2:0] c_sel,
    output logic       c_we,
    output logic [2:0] alu_op,
    output logic       ar_load,
    output logic       ir_load,
    output logic       dr_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       busy,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_A, S_FETCH_M, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MOV   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_SHR   = 4'd4;
    localparam logic [3:0] OP_LOAD  = 4'd5;
    localparam logic [3:0] OP_STORE = 4'd6;
    localparam logic [3:0] OP_JMPZ  = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd8;

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   w_bad;

    // The IR fields stay stable from DECODE until the next fetch, so the
    // legality check can be evaluated combinationally in any later state.
    assign w_bad = (op > OP_HALT) ||
                   ((op >= OP_MOV) && (op <= OP_STORE) && ((src == 3'd0) || (dst < 3'd3)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_DECODE) && w_bad)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next  = r_state;
        b_flag  = 3'd0;
        c_sel   = 3'd0;
        c_we    = 1'b0;
        alu_op  = 3'd0;
        ar_load = 1'b0;
        ir_load = 1'b0;
        dr_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        busy    = (r_state != S_IDLE) && (r_state != S_HALT);
        halted  = (r_state == S_HALT);
        illegal = r_illegal;

        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = S_FETCH_A;
            end
            S_FETCH_A: begin
                b_flag  = 3'd1;
                ar_load = 1'b1;
                w_next  = S_FETCH_M;
            end
            S_FETCH_M: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = (op == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                w_next = S_FETCH_A;
                if (!w_bad) begin
                    case (op)
                        OP_MOV, OP_ADD, OP_SUB, OP_SHR: begin
                            b_flag = src;
                            case (op)
                                OP_ADD:  alu_op = 3'd1;
                                OP_SUB:  alu_op = 3'd2;
                                OP_SHR:  alu_op = 3'd3;
                                default: alu_op = 3'd0;
                            endcase
                            w_next = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            b_flag  = src;
                            ar_load = 1'b1;
                            w_next  = S_MEM;
                        end
                        OP_JMPZ: begin
                            b_flag  = 3'd2;
                            pc_load = z_flag;
                        end
                        default: w_next = S_FETCH_A;
                    endcase
                end
            end
            S_MEM: begin
                if (op == OP_LOAD) begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        dr_load = 1'b1;
                        w_next  = S_WB;
                    end
                end else begin
                    b_flag = dst;
                    mem_wr = 1'b1;
                    if (mem_ready)
                        w_next = S_FETCH_A;
                end
            end
            S_WB: begin
                c_sel  = dst;
                c_we   = 1'b1;
                if (op == OP_LOAD)
                    b_flag = 3'd2;
                w_next = S_FETCH_A;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase

        // Reset wins over whatever state is still held, so the reset cycle is quiet.
        if (!rst_n) begin
            b_flag  = 3'd0;
            c_sel   = 3'd0;
            c_we    = 1'b0;
            alu_op  = 3'd0;
            ar_load = 1'b0;
            ir_load = 1'b0;
            dr_load = 1'b0;
            pc_inc  = 1'b0;
            pc_load = 1'b0;
            mem_rd  = 1'b0;
            mem_wr  = 1'b0;
            busy    = 1'b0;
            halted  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n, start, z_flag, mem_ready;
    logic [3:0] op;
    logic [2:0] src, dst;
    logic [2:0] b_flag, c_sel, alu_op;
    logic       c_we, ar_load, ir_load, dr_load, pc_inc, pc_load;
    logic       mem_rd, mem_wr, busy, halted, illegal;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .dst(dst),
        .z_flag(z_flag), .mem_ready(mem_ready), .b_flag(b_flag), .c_sel(c_sel),
        .c_we(c_we), .alu_op(alu_op), .ar_load(ar_load), .ir_load(ir_load),
        .dr_load(dr_load), .pc_inc(pc_inc), .pc_load(pc_load), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .busy(busy), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Packed view: b_flag[19:17] c_sel[16:14] c_we[13] alu_op[12:10] then 1-bit strobes.
    localparam logic [19:0] CWE = 20'd1 << 13;
    localparam logic [19:0] AR  = 20'd1 << 9;
    localparam logic [19:0] IR  = 20'd1 << 8;
    localparam logic [19:0] DR  = 20'd1 << 7;
    localparam logic [19:0] PCI = 20'd1 << 6;
    localparam logic [19:0] PCL = 20'd1 << 5;
    localparam logic [19:0] RD  = 20'd1 << 4;
    localparam logic [19:0] WR  = 20'd1 << 3;
    localparam logic [19:0] BSY = 20'd1 << 2;
    localparam logic [19:0] HLT = 20'd1 << 1;
    localparam logic [19:0] ILL = 20'd1;

    logic [19:0] act;
    assign act = {b_flag, c_sel, c_we, alu_op, ar_load, ir_load, dr_load, pc_inc,
                  pc_load, mem_rd, mem_wr, busy, halted, illegal};

    typedef struct {
        int          cyc;
        logic [19:0] exp;
        logic [19:0] mask;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [19:0] il = 20'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] fv(input logic [2:0] b, input logic [2:0] cs, input logic [2:0] alu);
        return {b, cs, 1'b0, alu, 10'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [19:0] e, input logic [19:0] m = '1);
        exp_t x;
        x.cyc  = cyc;
        x.exp  = e;
        x.mask = m;
        x.name = nm;
        sb.push_back(x);
    endtask

    // Runs FETCH_A, FETCH_M (memory ready at once) and DECODE; returns in the cycle after DECODE.
    task automatic fetch(input string nm);
        mem_ready = 1'b1;
        chk({nm, "_fa"}, fv(3'd1, 3'd0, 3'd0) | AR | BSY | il);
        tick();
        chk({nm, "_fm"}, IR | PCI | BSY | il, ~RD);
        tick();
        chk({nm, "_dec"}, BSY | il);
        tick();
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_chk++;
            $display("FAIL %s not sampled (cycle %0d, now %0d)", sb[0].name, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            n_chk++;
            if (((act ^ sb[0].exp) & sb[0].mask) == 20'd0)
                n_pass++;
            else
                $display("FAIL %s cyc=%0d got=%05h want=%05h mask=%05h",
                         sb[0].name, cyc, act, sb[0].exp, sb[0].mask);
            void'(sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired with %0d checks pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 4'd0; src = 3'd0; dst = 3'd0;
        z_flag = 1'b0; mem_ready = 1'b0;
        tick();
        chk("reset", 20'd0);
        tick();
        rst_n = 1'b1; start = 1'b1; op = 4'd2; src = 3'd3; dst = 3'd4;
        chk("idle_start", 20'd0);
        tick();
        start = 1'b0;

        // ADD R2<-R1+..: b_flag 1,0,0,3,0 then FETCH_A again in cycle 6
        fetch("add");
        chk("add_ex", fv(3'd3, 3'd0, 3'd1) | BSY);
        n_chk++;
        if (alu_op == 3'd1)
            n_pass++;
        else
            $display("FAIL add_ex_direct alu_op=%0d", alu_op);
        tick();
        chk("add_wb", fv(3'd0, 3'd4, 3'd0) | CWE | BSY);
        n_chk++;
        if (c_sel == 3'd4 && c_we == 1'b1)
            n_pass++;
        else
            $display("FAIL add_wb_direct c_sel=%0d c_we=%b", c_sel, c_we);
        tick();

        // LOAD src=R2 dst=R5 with memory three cycles late
        op = 4'd5; src = 3'd4; dst = 3'd7;
        fetch("ld");
        chk("ld_ex", fv(3'd4, 3'd0, 3'd0) | AR | BSY);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("ld_wait", RD | BSY);
            tick();
        end
        mem_ready = 1'b1;
        chk("ld_done", RD | DR | BSY);
        tick();
        chk("ld_wb", fv(3'd2, 3'd7, 3'd0) | CWE | BSY);
        n_chk++;
        if (b_flag == 3'd2)
            n_pass++;
        else
            $display("FAIL ld_wb_direct b_flag=%0d", b_flag);
        tick();

        op = 4'd4; src = 3'd1; dst = 3'd5;
        fetch("shr");
        chk("shr_ex", fv(3'd1, 3'd0, 3'd3) | BSY);
        tick();
        chk("shr_wb", fv(3'd0, 3'd5, 3'd0) | CWE | BSY);
        tick();

        op = 4'd7; z_flag = 1'b1;
        fetch("jz1");
        chk("jz1_ex", fv(3'd2, 3'd0, 3'd0) | PCL | BSY);
        tick();
        z_flag = 1'b0;
        fetch("jz0");
        chk("jz0_ex", fv(3'd2, 3'd0, 3'd0) | BSY);
        tick();

        op = 4'd6; src = 3'd5; dst = 3'd6;
        fetch("st");
        chk("st_ex", fv(3'd5, 3'd0, 3'd0) | AR | BSY);
        tick();
        chk("st_mem", fv(3'd6, 3'd0, 3'd0) | WR | BSY);
        tick();

        // Illegal MOV with src=0, then undefined op 12: flag sticks, no side effects
        op = 4'd1; src = 3'd0; dst = 3'd3;
        fetch("ill1");
        chk("ill1_ex", BSY | ILL);
        tick();
        il = ILL;
        op = 4'd12;
        fetch("ill12");
        chk("ill12_ex", BSY | ILL);
        tick();

        rst_n = 1'b0;
        chk("rst_clr", 20'd0);
        tick();
        rst_n = 1'b1; il = 20'd0; start = 1'b1; op = 4'd6; src = 3'd5; dst = 3'd6;
        chk("idle2", 20'd0);
        tick();
        start = 1'b0;

        // Reset in the middle of a STORE memory wait
        fetch("st2");
        chk("st2_ex", fv(3'd5, 3'd0, 3'd0) | AR | BSY);
        mem_ready = 1'b0;
        tick();
        chk("st2_wait", fv(3'd6, 3'd0, 3'd0) | WR | BSY);
        tick();
        chk("st2_wait2", fv(3'd6, 3'd0, 3'd0) | WR | BSY);
        tick();
        rst_n = 1'b0;
        chk("st2_rst", 20'd0);
        tick();
        rst_n = 1'b1; mem_ready = 1'b1;
        chk("post_rst", 20'd0);
        n_chk++;
        if (mem_wr == 1'b0 && busy == 1'b0)
            n_pass++;
        else
            $display("FAIL post_rst_direct mem_wr=%b busy=%b", mem_wr, busy);
        tick();
        chk("post_rst2", 20'd0);
        tick();

        // HALT ignores start until reset
        start = 1'b1; op = 4'd8;
        chk("idle3", 20'd0);
        tick();
        start = 1'b0;
        fetch("hlt");
        chk("halt", HLT);
        start = 1'b1;
        tick();
        chk("halt_hold", HLT);
        n_chk++;
        if (halted == 1'b1 && busy == 1'b0)
            n_pass++;
        else
            $display("FAIL halt_hold_direct halted=%b busy=%b", halted, busy);
        tick();
        chk("halt_hold2", HLT);
        tick();
        rst_n = 1'b0; start = 1'b0;
        chk("halt_rst", 20'd0);
        tick();
        rst_n = 1'b1;
        chk("idle4", 20'd0);
        tick();

        repeat (4) tick();
        while (sb.size() > 0) begin
            n_chk++;
            $display("FAIL %s never compared", sb[0].name);
            void'(sb.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
